// File: rtl/m_layer_pool_1_if.sv
// Bus bundle between the pool stage, the conv output buffer it reads
// and the next layer's buffer it writes.
interface m_layer_pool_1_if #(
  parameter int ADDR_W  = 10,
  parameter int OADDR_W = 8,
  parameter int DATA_W  = 8
);
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  d_in;
  logic [DATA_W-1:0]  pool_out;
  logic               pool_valid;
  logic [OADDR_W-1:0] pool_addr;

  // Pool stage side: issues reads, consumes buffer data, produces pixels.
  modport master (
    output rd_en, rd_addr, pool_out, pool_valid, pool_addr,
    input  d_in
  );

  // Buffer / consumer side.
  modport slave (
    input  rd_en, rd_addr, pool_out, pool_valid, pool_addr,
    output d_in
  );
endinterface

// File: rtl/m_layer_pool_1.sv
// 2x2 stride-2 max-pool of the layer-1 conv buffer. After start it streams
// one read per cycle (four per window, raster order), tracks the running
// maximum one cycle behind the reads and strobes one pooled pixel per window.
module m_layer_pool_1 #(
  parameter int IMG_W   = 26,
  parameter int IMG_H   = 26,
  parameter int ADDR_W  = 10,
  parameter int OADDR_W = 8,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  m_layer_pool_1_if.master  bus,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0]  OW_M1  = ADDR_W'(IMG_W / 2 - 1);
  localparam logic [ADDR_W-1:0]  OH_M1  = ADDR_W'(IMG_H / 2 - 1);
  localparam logic [ADDR_W-1:0]  OFF_W  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]  OFF_W1 = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0]  ROW2   = ADDR_W'(2 * IMG_W);
  localparam logic [OADDR_W-1:0] NP_M1  = OADDR_W'((IMG_W / 2) * (IMG_H / 2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  // Read-side counters describe the read being issued this cycle.
  logic [1:0]        ph_q, ph_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              last_rd;

  // Stage p1 is aligned with d_in (one cycle behind the read).
  logic              vld_p1_q, vld_p1_d;
  logic [1:0]        ph_p1_q, ph_p1_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] pool_out_q, pool_out_d;
  logic              pool_valid_q, pool_valid_d;
  logic [OADDR_W-1:0] pool_addr_q, pool_addr_d;

  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign last_rd = (state_q == S_READ) && (ph_q == 2'd3) &&
                   (col_q == OW_M1) && (row_q == OH_M1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: single pass, DONE is terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  if (last_rd) state_d = S_DRAIN;
      S_DRAIN: if (pool_valid_q && (pool_addr_q == NP_M1)) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  // FSM outputs: read strobe/address and status.
  always_comb begin
    bus.rd_en   = (state_q == S_READ);
    bus.rd_addr = '0;
    if (state_q == S_READ) begin
      case (ph_q)
        2'd0:    bus.rd_addr = base_q;
        2'd1:    bus.rd_addr = base_q + ADDR_W'(1);
        2'd2:    bus.rd_addr = base_q + OFF_W;
        default: bus.rd_addr = base_q + OFF_W1;
      endcase
    end
    busy = (state_q == S_READ) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

  // Window walk: phase fastest, then column, then row pair.
  always_comb begin
    ph_d       = ph_q;
    col_d      = col_q;
    row_d      = row_q;
    base_d     = base_q;
    row_base_d = row_base_q;
    if (state_q == S_IDLE) begin
      ph_d       = '0;
      col_d      = '0;
      row_d      = '0;
      base_d     = '0;
      row_base_d = '0;
    end else if (state_q == S_READ) begin
      ph_d = ph_q + 2'd1;
      if (ph_q == 2'd3) begin
        if (col_q == OW_M1) begin
          col_d      = '0;
          row_d      = row_q + ADDR_W'(1);
          row_base_d = row_base_q + ROW2;
          base_d     = row_base_q + ROW2;
        end else begin
          col_d  = col_q + ADDR_W'(1);
          base_d = base_q + ADDR_W'(2);
        end
      end
    end
  end

  // Stage p1: running max over the window, emit on its fourth sample.
  always_comb begin
    vld_p1_d     = (state_q == S_READ);
    ph_p1_d      = ph_q;
    max_d        = max_q;
    pool_out_d   = pool_out_q;
    pool_valid_d = 1'b0;
    pool_addr_d  = pool_addr_q;
    if (pool_valid_q && (pool_addr_q != NP_M1)) pool_addr_d = pool_addr_q + OADDR_W'(1);
    if (vld_p1_q) begin
      case (ph_p1_q)
        2'd0:    max_d = bus.d_in;
        2'd3: begin
          pool_out_d   = umax(max_q, bus.d_in);
          pool_valid_d = 1'b1;
        end
        default: max_d = umax(max_q, bus.d_in);
      endcase
    end
  end

  // Counter and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      base_q       <= '0;
      row_base_q   <= '0;
      vld_p1_q     <= 1'b0;
      ph_p1_q      <= '0;
      max_q        <= '0;
      pool_out_q   <= '0;
      pool_valid_q <= 1'b0;
      pool_addr_q  <= '0;
    end else begin
      ph_q         <= ph_d;
      col_q        <= col_d;
      row_q        <= row_d;
      base_q       <= base_d;
      row_base_q   <= row_base_d;
      vld_p1_q     <= vld_p1_d;
      ph_p1_q      <= ph_p1_d;
      max_q        <= max_d;
      pool_out_q   <= pool_out_d;
      pool_valid_q <= pool_valid_d;
      pool_addr_q  <= pool_addr_d;
    end
  end

  assign bus.pool_out   = pool_out_q;
  assign bus.pool_valid = pool_valid_q;
  assign bus.pool_addr  = pool_addr_q;

endmodule

// File: tb/tb_m_layer_pool_1.sv
module tb_m_layer_pool_1;
  localparam int W = 26, H = 26, OW = 13, OH = 13, NP = 169, NRD = 676;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  m_layer_pool_1_if #(.ADDR_W(10), .OADDR_W(8), .DATA_W(8)) bus();

  m_layer_pool_1 #(.IMG_W(W), .IMG_H(H), .ADDR_W(10), .OADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Conv buffer model: 1-cycle read latency.
  logic [7:0] mem [0:NRD-1];
  always @(posedge clk) if (bus.rd_en) bus.d_in <= mem[bus.rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  typedef struct { int addr; int data; } exp_t;
  exp_t sb[$];
  int strobes, rdcnt, rdlast, F, badaddr;
  int rdlog [0:NRD-1];
  int vcyc  [0:NP-1];
  int got   [0:NP-1];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model(input int k);
    int r, c, b, m;
    r = k / OW; c = k % OW;
    b = 2 * r * W + 2 * c;
    m = mem[b];
    if (mem[b+1] > m)   m = mem[b+1];
    if (mem[b+W] > m)   m = mem[b+W];
    if (mem[b+W+1] > m) m = mem[b+W+1];
    return m;
  endfunction

  // Monitor: logs reads and checks every strobe against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.rd_en) begin
      if (rdcnt == 0) F = cyc;
      if (rdcnt < NRD) rdlog[rdcnt] = int'(bus.rd_addr);
      if (int'(bus.rd_addr) >= NRD) badaddr++;
      rdlast = cyc;
      rdcnt++;
    end
    if (rst && bus.pool_valid) begin
      if (sb.size() == 0) chk("unexpected_strobe_addr", int'(bus.pool_addr), -1);
      else begin
        e = sb.pop_front();
        chk("pool_addr", int'(bus.pool_addr), e.addr);
        chk("pool_out", int'(bus.pool_out), e.data);
      end
      if (int'(bus.pool_addr) < NP) begin
        got[bus.pool_addr]  = int'(bus.pool_out);
        vcyc[bus.pool_addr] = cyc;
      end
      strobes++;
    end
  end

  task automatic do_reset();
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_stats();
    sb.delete();
    strobes = 0; rdcnt = 0; badaddr = 0; F = -1; rdlast = -1;
    for (int i = 0; i < NP; i++) begin got[i] = -1; vcyc[i] = -1; end
  endtask

  task automatic push_exp();
    for (int k = 0; k < NP; k++) sb.push_back('{k, model(k)});
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin @(negedge clk); n++; end
    chk("done_reached", int'(done), 1);
  endtask

  task automatic finish_checks(input string tag);
    chk({tag, "_strobes"}, strobes, NP);
    chk({tag, "_rd_cycles"}, rdcnt, NRD);
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_rd_addr_range"}, badaddr, 0);
    repeat (10) @(negedge clk);
    chk({tag, "_done_held"}, int'(done), 1);
    chk({tag, "_no_extra"}, strobes, NP);
    chk({tag, "_rd_idle"}, int'(bus.rd_en), 0);
    chk({tag, "_last_addr"}, int'(bus.pool_addr), NP - 1);
  endtask

  task automatic run(input bit pulse, input string tag);
    clear_stats();
    push_exp();
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (pulse) start = 1'b0;
    wait_done(3000);
    start = 1'b0;
    finish_checks(tag);
  endtask

  task automatic ramp();
    for (int i = 0; i < NRD; i++) mem[i] = 8'(i % 256);
  endtask

  initial begin
    int bad, n, nz;
    int seq0 [0:7];
    int seqw [0:7];
    int pos  [0:3];
    seq0 = '{0, 1, 26, 27, 2, 3, 28, 29};
    seqw = '{24, 25, 50, 51, 52, 53, 78, 79};
    pos  = '{0, 1, 26, 27};
    clear_stats();

    // 1: reset holds everything at zero even with start high
    rst = 1'b0; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_ctrl", int'({bus.rd_en, bus.pool_valid, busy, done}), 0);
      chk("rst_rd_addr", int'(bus.rd_addr), 0);
      chk("rst_pool", int'(bus.pool_out) + int'(bus.pool_addr), 0);
    end
    start = 1'b0; rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_rd_cycles", rdcnt, 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);

    // 2 + 4: ramp run with hand values and timing
    ramp();
    run(1'b0, "ramp");
    chk("ramp_p0", got[0], 27);
    chk("ramp_p1", got[1], 29);
    chk("ramp_p13", got[13], 79);
    chk("ramp_p168", got[168], 163);
    for (int i = 0; i < 8; i++) chk("rd_seq_start", rdlog[i], seq0[i]);
    for (int i = 0; i < 8; i++) chk("rd_seq_wrap", rdlog[48 + i], seqw[i]);
    chk("rd_continuous", rdlast - F, NRD - 1);
    chk("latency_k0", vcyc[0] - F, 5);
    chk("latency_k1", vcyc[1] - F, 9);
    bad = 0;
    for (int k = 0; k < NP; k++) if (vcyc[k] != F + 4 * k + 5) bad++;
    chk("latency_all", bad, 0);

    // 3: single 255 in each position of window 0
    for (int p = 0; p < 4; p++) begin
      do_reset();
      for (int i = 0; i < NRD; i++) mem[i] = 8'd0;
      mem[pos[p]] = 8'd255;
      run(1'b0, "maxpos");
      chk("maxpos_p0", got[0], 255);
      nz = 0;
      for (int k = 1; k < NP; k++) if (got[k] != 0) nz++;
      chk("maxpos_others_zero", nz, 0);
    end

    // 5: reset mid-run at output 60, then a clean rerun
    do_reset();
    ramp();
    clear_stats();
    push_exp();
    @(negedge clk); start = 1'b1;
    n = 0;
    while (!(bus.pool_valid && bus.pool_addr == 8'd60) && n < 1000) begin
      @(negedge clk); n++;
    end
    chk("midrun_reached_60", int'(bus.pool_addr), 60);
    #1 rst = 1'b0;
    #1;
    chk("midrun_ctrl", int'({bus.rd_en, bus.pool_valid, busy, done}), 0);
    chk("midrun_data", int'(bus.pool_out) + int'(bus.pool_addr) + int'(bus.rd_addr), 0);
    start = 1'b0;
    sb.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    run(1'b0, "restart");
    chk("restart_p0", got[0], 27);
    chk("restart_p168", got[168], 163);

    // 6: one-cycle start pulse still runs to completion
    do_reset();
    ramp();
    run(1'b1, "glitch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
